// File: rtl/fault_pkg.sv
// Shared types and constants for the protection-flag front end (fault_capture).
package fault_pkg;

  typedef enum logic [1:0] {
    FC_RUN  = 2'd0,
    FC_TRIP = 2'd1,
    FC_HOLD = 2'd2
  } fc_state_t;

  localparam int unsigned FLT_BUSOVP  = 0;
  localparam int unsigned FLT_IP_OCP  = 1;
  localparam int unsigned FLT_INVOCP1 = 2;
  localparam int unsigned FLT_OP_OVP1 = 3;
  localparam int unsigned FLT_INVOCP2 = 4;
  localparam int unsigned FLT_OP_OVP2 = 5;

  localparam int unsigned FIRST_NONE = 0;

endpackage

// File: rtl/fault_filter.sv
// One fault channel: 2-FF synchroniser followed by a saturating run-length debounce counter.
module fault_filter
  import fault_pkg::*;
#(
  parameter int unsigned FILT_CNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic enable,
  output logic sync,
  output logic set_pulse
);

  localparam int unsigned CW = $clog2(FILT_CNT + 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = raw_in;
    sync_d = meta_q;
    cnt_d  = '0;
    // Any low synced cycle restarts the run; a disabled channel stays at zero.
    if (enable && sync_q) begin
      if (cnt_q == CW'(FILT_CNT)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign sync      = sync_q;
  assign set_pulse = enable && sync_q && (cnt_q == CW'(FILT_CNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fault_capture.sv
// Sticky fault latch, first-fault record and PwmEn gating with clear hold-off.
// Optional FAULT_CAPTURE_MASK_EN adds FltMask (1 = channel disabled).
module fault_capture
  import fault_pkg::*;
#(
  parameter int unsigned N_FLT    = 6,
  parameter int unsigned FILT_CNT = 8,
  parameter int unsigned HOLD_CNT = 1000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_FLT-1:0]             FaultIn,
  input  logic                         FaultClr,
`ifdef FAULT_CAPTURE_MASK_EN
  input  logic [N_FLT-1:0]             FltMask,
`endif
  output logic [N_FLT-1:0]             FaultLatch,
  output logic [$clog2(N_FLT+1)-1:0]   FirstFlt,
  output logic                         PwmEn,
  output logic                         ClrRej
);

  localparam int unsigned FW = $clog2(N_FLT + 1);
  localparam int unsigned HW = $clog2(HOLD_CNT + 1);

  fc_state_t         state_q, state_d;
  logic [N_FLT-1:0]  latch_q, latch_d;
  logic [FW-1:0]     first_q, first_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              pwm_q, pwm_d;
  logic              clrrej_q, clrrej_d;

  logic [N_FLT-1:0]  chan_en;
  logic [N_FLT-1:0]  sync_vec;
  logic [N_FLT-1:0]  set_vec;
  logic              any_set;
  logic              quiet;
  logic              accept;

`ifdef FAULT_CAPTURE_MASK_EN
  assign chan_en = ~FltMask;
`else
  assign chan_en = '1;
`endif

  for (genvar g = 0; g < N_FLT; g++) begin : g_flt
    fault_filter #(
      .FILT_CNT (FILT_CNT)
    ) u_filt (
      .clk       (CLK),
      .rst       (RST),
      .raw_in    (FaultIn[g]),
      .enable    (chan_en[g]),
      .sync      (sync_vec[g]),
      .set_pulse (set_vec[g])
    );
  end

  // Descending scan so the lowest set channel is the one that sticks.
  function automatic logic [FW-1:0] first_of(input logic [N_FLT-1:0] v);
    logic [FW-1:0] r;
    r = '0;
    for (int unsigned i = N_FLT; i > 0; i--) begin
      if (v[i-1]) r = FW'(i);
    end
    return r;
  endfunction

  assign any_set = |set_vec;
  assign quiet   = ~|(sync_vec & chan_en);
  assign accept  = (state_q == FC_TRIP) && FaultClr && !any_set && quiet;

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    first_d  = first_q;
    hold_d   = hold_q;
    clrrej_d = 1'b0;

    if (any_set) begin
      latch_d = latch_q | set_vec;
      if (first_q == FW'(FIRST_NONE)) first_d = first_of(set_vec);
    end

    unique case (state_q)
      FC_RUN: begin
        if (any_set) state_d = FC_TRIP;
      end
      FC_TRIP: begin
        if (FaultClr) begin
          if (accept) begin
            latch_d = '0;
            first_d = FW'(FIRST_NONE);
            hold_d  = '0;
            state_d = FC_HOLD;
          end else begin
            clrrej_d = 1'b1;
          end
        end
      end
      FC_HOLD: begin
        if (any_set) begin
          state_d = FC_TRIP;
          hold_d  = '0;
        end else if (hold_q == HW'(HOLD_CNT - 1)) begin
          state_d = FC_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = FC_HOLD;
    endcase

    pwm_d = (state_d == FC_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FC_HOLD;
      latch_q  <= '0;
      first_q  <= '0;
      hold_q   <= '0;
      pwm_q    <= 1'b0;
      clrrej_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      first_q  <= first_d;
      hold_q   <= hold_d;
      pwm_q    <= pwm_d;
      clrrej_q <= clrrej_d;
    end
  end

  assign FaultLatch = latch_q;
  assign FirstFlt   = first_q;
  assign PwmEn      = pwm_q;
  assign ClrRej     = clrrej_q;

endmodule

// File: tb/tb_fault_capture.sv
// Bench for fault_capture (FILT_CNT=4, HOLD_CNT=10): scripted vectors plus random traffic vs a reference model.
module tb_fault_capture;

  localparam int FILT = 4;
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] FaultIn = '0;
  logic       FaultClr = 1'b0;
  logic [5:0] mask_v = '0;
  logic [5:0] FaultLatch;
  logic [2:0] FirstFlt;
  logic       PwmEn;
  logic       ClrRej;

  always #5 clk = ~clk;

  fault_capture #(
    .N_FLT    (6),
    .FILT_CNT (FILT),
    .HOLD_CNT (HOLD)
  ) dut (
    .CLK        (clk),
    .RST        (RST),
    .FaultIn    (FaultIn),
    .FaultClr   (FaultClr),
`ifdef FAULT_CAPTURE_MASK_EN
    .FltMask    (mask_v),
`endif
    .FaultLatch (FaultLatch),
    .FirstFlt   (FirstFlt),
    .PwmEn      (PwmEn),
    .ClrRej     (ClrRej)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sync = raw delayed two edges; a channel latches when its
  // unbroken run of synced-high edges reaches FILT. PwmEn is allowed once not
  // tripped and HOLD edges have passed since the last hold start.
  logic [5:0] m_hist[$];
  int         m_run[6];
  logic [5:0] m_latch;
  logic [2:0] m_first;
  bit         m_tripped;
  int         m_n, m_hold_start;
  logic       m_pwm, m_rej;

  task automatic model_edge(input logic [5:0] raw, input logic clr, input logic rst, input logic [5:0] msk);
    logic [5:0] sync, set;
    bit quiet;
    int k;
    if (rst) begin
      m_hist.delete();
      m_hist.push_back(6'h00);
      m_hist.push_back(6'h00);
      foreach (m_run[i]) m_run[i] = 0;
      m_latch = '0; m_first = '0; m_tripped = 0;
      m_n = 0; m_hold_start = 0; m_pwm = 0; m_rej = 0;
      return;
    end
    m_n++;
    sync = m_hist[0];
    set  = '0;
    for (int i = 0; i < 6; i++) begin
      if (sync[i] && !msk[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == FILT) set[i] = 1'b1;
    end
    quiet = ((sync & ~msk) == 6'h00);
    m_rej = 0;
    if (m_tripped && clr) begin
      if (set == 6'h00 && quiet) begin
        m_latch = '0; m_first = '0; m_tripped = 0; m_hold_start = m_n;
      end else begin
        m_rej = 1;
      end
    end
    if (set != 6'h00) begin
      if (m_first == 3'd0) begin
        k = 0;
        while (!set[k]) k++;
        m_first = 3'(k + 1);
      end
      m_latch   = m_latch | set;
      m_tripped = 1;
    end
    m_pwm = !m_tripped && ((m_n - m_hold_start) >= HOLD);
    void'(m_hist.pop_front());
    m_hist.push_back(raw);
  endtask

  task automatic step(input logic [5:0] raw, input logic clr, input logic rst);
    @(negedge clk);
    FaultIn  = raw;
    FaultClr = clr;
    RST      = rst;
    @(posedge clk);
    model_edge(raw, clr, rst, mask_v);
    #1;
    chk("m_latch", 32'(FaultLatch), 32'(m_latch));
    chk("m_first", 32'(FirstFlt),   32'(m_first));
    chk("m_pwm",   32'(PwmEn),      32'(m_pwm));
    chk("m_rej",   32'(ClrRej),     32'(m_rej));
  endtask

  task automatic expect_out(input string name, input logic [5:0] el, input logic [2:0] ef,
                            input logic ep, input logic er);
    chk({name, ".latch"}, 32'(FaultLatch), 32'(el));
    chk({name, ".first"}, 32'(FirstFlt),   32'(ef));
    chk({name, ".pwm"},   32'(PwmEn),      32'(ep));
    chk({name, ".rej"},   32'(ClrRej),     32'(er));
  endtask

  typedef struct {
    logic [5:0] raw;
    logic       clr;
    int         n;
    logic [5:0] e_latch;
    logic [2:0] e_first;
    logic       e_pwm;
    logic       e_rej;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [5:0] raw, input logic clr, input int n, input logic [5:0] el,
                              input logic [2:0] ef, input logic ep, input logic er);
    vec_t v;
    v.raw = raw; v.clr = clr; v.n = n;
    v.e_latch = el; v.e_first = ef; v.e_pwm = ep; v.e_rej = er;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] raw;
    logic clr, rst;

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    expect_out("reset", 6'h00, 3'd0, 1'b0, 1'b0);

    vecs.push_back(mk(6'h00, 0, 9,  6'h00, 0, 0, 0)); // hold-off after reset
    vecs.push_back(mk(6'h00, 0, 1,  6'h00, 0, 1, 0));
    vecs.push_back(mk(6'h04, 0, 3,  6'h00, 0, 1, 0)); // 3-cycle glitch
    vecs.push_back(mk(6'h00, 0, 4,  6'h00, 0, 1, 0));
    vecs.push_back(mk(6'h04, 0, 5,  6'h00, 0, 1, 0));
    vecs.push_back(mk(6'h04, 0, 1,  6'h04, 3, 0, 0)); // 6th edge latches
    vecs.push_back(mk(6'h04, 1, 1,  6'h04, 3, 0, 1)); // refused, source active
    vecs.push_back(mk(6'h00, 0, 2,  6'h04, 3, 0, 0));
    vecs.push_back(mk(6'h00, 1, 1,  6'h00, 0, 0, 0)); // accepted
    vecs.push_back(mk(6'h00, 0, 9,  6'h00, 0, 0, 0));
    vecs.push_back(mk(6'h00, 0, 1,  6'h00, 0, 1, 0));
    vecs.push_back(mk(6'h12, 0, 5,  6'h00, 0, 1, 0));
    vecs.push_back(mk(6'h12, 0, 1,  6'h12, 2, 0, 0)); // simultaneous: lowest wins
    vecs.push_back(mk(6'h13, 0, 6,  6'h13, 2, 0, 0)); // later fault keeps FirstFlt
    vecs.push_back(mk(6'h00, 0, 2,  6'h13, 2, 0, 0));
    vecs.push_back(mk(6'h20, 1, 1,  6'h00, 0, 0, 0)); // accepted, ch5 rising
    vecs.push_back(mk(6'h20, 0, 4,  6'h00, 0, 0, 0));
    vecs.push_back(mk(6'h20, 0, 1,  6'h20, 6, 0, 0)); // trip at hold age 5
    vecs.push_back(mk(6'h20, 0, 10, 6'h20, 6, 0, 0));

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) step(vecs[i].raw, vecs[i].clr, 1'b0);
      expect_out($sformatf("vec%0d", i), vecs[i].e_latch, vecs[i].e_first, vecs[i].e_pwm, vecs[i].e_rej);
    end

    // Reset while latched, then reset again part-way through the hold-off.
    step(6'h00, 1'b0, 1'b1);
    expect_out("rst_latched", 6'h00, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) step(6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 1'b1);
    for (int c = 0; c < 9; c++) step(6'h00, 1'b0, 1'b0);
    expect_out("midhold_9", 6'h00, 3'd0, 1'b0, 1'b0);
    step(6'h00, 1'b0, 1'b0);
    expect_out("midhold_10", 6'h00, 3'd0, 1'b1, 1'b0);

`ifdef FAULT_CAPTURE_MASK_EN
    mask_v = 6'h01;
    for (int c = 0; c < 10; c++) step(6'h01, 1'b0, 1'b0);
    expect_out("mask_steady", 6'h00, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step(6'h09, 1'b0, 1'b0);
    expect_out("mask_trip", 6'h08, 3'd4, 1'b0, 1'b0);
    step(6'h01, 1'b0, 1'b0);
    step(6'h01, 1'b0, 1'b0);
    step(6'h01, 1'b1, 1'b0);
    expect_out("mask_clr", 6'h00, 3'd0, 1'b0, 1'b0);
    mask_v = 6'h00;
`endif

    raw = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(11) == 0) raw[k] = ~raw[k];
      end
      clr = ($urandom_range(5) == 0);
      rst = ($urandom_range(499) == 0);
`ifdef FAULT_CAPTURE_MASK_EN
      if ($urandom_range(199) == 0) mask_v = 6'($urandom_range(63));
`endif
      step(raw, clr, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
